// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_pkg
//  Description : Shared types and constants for the instruction fetch unit.
//  Revision    : 1.0
// ============================================================================
package ifu_pkg;

    localparam int          IFU_AW       = 13;
    localparam logic [12:0] IFU_RESET_PC = 13'h1000;
    localparam logic [12:0] IFU_EXC_VEC  = 13'h0180;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        VALID = 1'b1
    } ifu_state_e;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/ifu_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_if
//  Description : Instruction-memory read port (address out, word back).
//  Revision    : 1.0
// ============================================================================
interface ifu_if #(
    parameter int AW = 13
);
    logic [AW-1:0] im_addr;
    logic [31:0]   im_dout;

    modport master (output im_addr, input  im_dout);
    modport slave  (input  im_addr, output im_dout);

endinterface : ifu_if
`default_nettype wire

// File: rtl/ifu_npc.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_npc
//  Description : Combinational next-PC calculator (seq/branch/jump/jr).
//  Revision    : 1.0
// ============================================================================
module ifu_npc
    import ifu_pkg::*;
#(
    parameter int AW = IFU_AW
) (
    input  wire logic [AW-1:0] pc,
    input  wire logic [1:0]    npc_sel,
    input  wire logic          br_taken,
    input  wire logic [15:0]   imm16,
    input  wire logic [25:0]   j_index,
    input  wire logic [31:0]   jr_target,
    output logic      [AW-1:0] npc,
    output logic      [AW-1:0] pc4
);

    localparam logic [AW-1:0] C_FOUR = AW'(4);

    logic [AW-1:0] w_br_off;
    logic [AW-1:0] w_br_tgt;
    logic [AW-1:0] w_j_tgt;
    logic [AW-1:0] w_jr_tgt;
    logic          w_unused;

    assign pc4      = pc + C_FOUR;
    assign w_br_off = AW'({{16{imm16[15]}}, imm16, 2'b00});
    assign w_br_tgt = pc4 + w_br_off;
    assign w_j_tgt  = {j_index[AW-3:0], 2'b00};
    // Low two bits of the register target are dropped, never faulted.
    assign w_jr_tgt = {jr_target[AW-1:2], 2'b00};

    assign w_unused = ^{jr_target[31:AW], jr_target[1:0], j_index[25:AW-2]};

    always_comb begin
        npc = pc4;
        unique case (npc_sel_e'(npc_sel))
            NPC_SEQ: npc = pc4;
            NPC_BR:  npc = br_taken ? w_br_tgt : pc4;
            NPC_J:   npc = w_j_tgt;
            NPC_JR:  npc = w_jr_tgt;
            default: npc = pc4;
        endcase
    end

endmodule : ifu_npc
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
//  Module      : ifu
//  Description : Instruction fetch unit: PC, IR, EPC/EXL and fetch handshake.
//  Revision    : 1.0
// ============================================================================
module ifu
    import ifu_pkg::*;
#(
    parameter int            AW       = IFU_AW,
    parameter logic [AW-1:0] RESET_PC = AW'(IFU_RESET_PC),
    parameter logic [AW-1:0] EXC_VEC  = AW'(IFU_EXC_VEC)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    ifu_if.master              imem,
    output logic      [31:0]   ir,
    output logic               ir_valid,
    input  wire logic          npc_we,
    input  wire logic [1:0]    npc_sel,
    input  wire logic          br_taken,
    input  wire logic [15:0]   imm16,
    input  wire logic [25:0]   j_index,
    input  wire logic [31:0]   jr_target,
    input  wire logic          eret,
    input  wire logic          irq,
    output logic      [AW-1:0] pc,
    output logic      [AW-1:0] pc4,
    output logic      [AW-1:0] epc,
    output logic               exl
);

    ifu_state_e    state_q, state_d;
    logic [AW-1:0] pc_q,  pc_d;
    logic [AW-1:0] epc_q, epc_d;
    logic [31:0]   ir_q,  ir_d;
    logic          exl_q, exl_d;
    logic [AW-1:0] w_npc;

    ifu_npc #(
        .AW (AW)
    ) u_npc (
        .pc        (pc_q),
        .npc_sel   (npc_sel),
        .br_taken  (br_taken),
        .imm16     (imm16),
        .j_index   (j_index),
        .jr_target (jr_target),
        .npc       (w_npc),
        .pc4       (pc4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            ir_q    <= '0;
            exl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            ir_q    <= ir_d;
            exl_q   <= exl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        ir_d    = ir_q;
        exl_d   = exl_q;
        unique case (state_q)
            FETCH: begin
                ir_d    = imem.im_dout;
                state_d = VALID;
            end
            VALID: begin
                if (npc_we) begin
                    state_d = FETCH;
                    // eret outranks irq so a pending request cannot block the return.
                    if (eret) begin
                        pc_d  = epc_q;
                        exl_d = 1'b0;
                    end else if (irq && !exl_q) begin
                        epc_d = w_npc;
                        pc_d  = EXC_VEC;
                        exl_d = 1'b1;
                    end else begin
                        pc_d  = w_npc;
                    end
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign imem.im_addr = pc_q;
    assign pc           = pc_q;
    assign epc          = epc_q;
    assign exl          = exl_q;
    assign ir           = ir_q;
    assign ir_valid     = (state_q == VALID);

endmodule : ifu
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu
//  Description : Self-checking bench for ifu against a behavioural model.
//  Revision    : 1.0
// ============================================================================
module tb_ifu;

    logic        clk;
    logic        rst_n;
    logic [31:0] ir;
    logic        ir_valid;
    logic        npc_we;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] j_index;
    logic [31:0] jr_target;
    logic        eret;
    logic        irq;
    logic [12:0] pc, pc4, epc;
    logic        exl;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:2047];
    int m_pc, m_epc, m_exl;

    ifu_if #(.AW(13)) bus ();
    assign bus.im_dout = mem[bus.im_addr[12:2]];

    ifu #(.AW(13), .RESET_PC(13'h1000), .EXC_VEC(13'h0180)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem      (bus),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .npc_we    (npc_we),
        .npc_sel   (npc_sel),
        .br_taken  (br_taken),
        .imm16     (imm16),
        .j_index   (j_index),
        .jr_target (jr_target),
        .eret      (eret),
        .irq       (irq),
        .pc        (pc),
        .pc4       (pc4),
        .epc       (epc),
        .exl       (exl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic int ref_npc(input int cur, input logic [1:0] sel, input logic br,
                                   input logic [15:0] imm, input logic [25:0] jidx,
                                   input logic [31:0] jrt);
        int p4;
        p4 = (cur + 4) % 8192;
        case (sel)
            2'd1:    return br ? (((p4 + 4 * int'($signed(imm))) % 8192) + 8192) % 8192 : p4;
            2'd2:    return (int'(jidx) * 4) % 8192;
            2'd3:    return (int'(jrt % 8192) / 4) * 4;
            default: return p4;
        endcase
    endfunction

    task automatic check_arch(input string tag);
        if (pc !== 13'(m_pc)) begin
            failures++; $display("FAIL %s pc got=%h exp=%h", tag, pc, 13'(m_pc));
        end
        checks++;
        if (bus.im_addr !== 13'(m_pc)) begin
            failures++; $display("FAIL %s im_addr got=%h exp=%h", tag, bus.im_addr, 13'(m_pc));
        end
        checks++;
        if (pc4 !== 13'((m_pc + 4) % 8192)) begin
            failures++; $display("FAIL %s pc4 got=%h exp=%h", tag, pc4, 13'((m_pc + 4) % 8192));
        end
        checks++;
        if (epc !== 13'(m_epc) || exl !== 1'(m_exl)) begin
            failures++;
            $display("FAIL %s epc/exl got=%h/%b exp=%h/%b", tag, epc, exl, 13'(m_epc), 1'(m_exl));
        end
        checks++;
    endtask

    // One accepted advance, the fetch that follows, then a stall of the given length.
    task automatic advance(input string tag, input logic [1:0] sel, input logic br,
                           input logic [15:0] imm, input logic [25:0] jidx,
                           input logic [31:0] jrt, input logic er, input logic iq,
                           input int stall);
        int nxt;
        logic [31:0] exp_ir;
        @(negedge clk);
        npc_sel = sel; br_taken = br; imm16 = imm; j_index = jidx;
        jr_target = jrt; eret = er; irq = iq; npc_we = 1'b1;
        nxt = ref_npc(m_pc, sel, br, imm, jidx, jrt);
        @(posedge clk); #1;
        if (er) begin
            m_pc = m_epc; m_exl = 0;
        end else if (iq && m_exl == 0) begin
            m_epc = nxt; m_pc = 'h180; m_exl = 1;
        end else begin
            m_pc = nxt;
        end
        check_arch(tag);
        if (ir_valid !== 1'b0) begin
            failures++; $display("FAIL %s ir_valid_low got=%b exp=0", tag, ir_valid);
        end
        checks++;
        // npc_we/eret/irq stay asserted across the fetch edge and must be ignored.
        @(posedge clk); #1;
        exp_ir = mem[m_pc / 4];
        check_arch({tag, "_fetch"});
        if (ir !== exp_ir || ir_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s ir got=%h/%b exp=%h/1", tag, ir, ir_valid, exp_ir);
        end
        checks++;
        npc_we = 1'b0; eret = 1'b0; irq = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (ir !== exp_ir || ir_valid !== 1'b1 || pc !== 13'(m_pc)) begin
                failures++;
                $display("FAIL %s stall ir/pc got=%h/%h exp=%h/%h", tag, ir, pc, exp_ir, 13'(m_pc));
            end
            checks++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_pc = 'h1000; m_epc = 0; m_exl = 0;
        repeat (3) @(posedge clk);
        #1;
        check_arch("reset");
        if (ir !== 32'h0 || ir_valid !== 1'b0) begin
            failures++; $display("FAIL reset ir got=%h/%b exp=0/0", ir, ir_valid);
        end
        checks++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        if (ir !== 32'h3C010001 || ir_valid !== 1'b1) begin
            failures++; $display("FAIL first_fetch ir got=%h/%b exp=3c010001/1", ir, ir_valid);
        end
        checks++;
    endtask

    task automatic test_seq_stall();
        advance("seq", 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 5);
    endtask

    task automatic test_flow();
        advance("seq2",   2'd0, 1'b0, 16'h0,    26'h0,     32'h0,       1'b0, 1'b0, 0);
        advance("br_tk",  2'd1, 1'b1, 16'hFFFE, 26'h0,     32'h0,       1'b0, 1'b0, 1);
        advance("seq3",   2'd0, 1'b0, 16'h0,    26'h0,     32'h0,       1'b0, 1'b0, 0);
        advance("br_nt",  2'd1, 1'b0, 16'hFFFE, 26'h0,     32'h0,       1'b0, 1'b0, 0);
        advance("jump",   2'd2, 1'b0, 16'h0,    26'h400,   32'h0,       1'b0, 1'b0, 0);
        advance("seq4",   2'd0, 1'b0, 16'h0,    26'h0,     32'h0,       1'b0, 1'b0, 0);
        advance("seq5",   2'd0, 1'b0, 16'h0,    26'h0,     32'h0,       1'b0, 1'b0, 0);
        advance("jr",     2'd3, 1'b0, 16'h0,    26'h0,     32'h00001013, 1'b0, 1'b0, 0);
    endtask

    task automatic test_irq();
        advance("irq_in", 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 0);
        advance("irq_masked1", 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 0);
        advance("irq_masked2", 2'd2, 1'b0, 16'h0, 26'h123, 32'h0, 1'b0, 1'b1, 0);
        advance("eret", 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1, 0);
    endtask

    task automatic test_wrap();
        advance("to_top", 2'd3, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFE, 1'b0, 1'b0, 0);
        advance("wrap",   2'd0, 1'b0, 16'h0, 26'h0, 32'h0,         1'b0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            advance("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    16'($urandom), 26'($urandom), $urandom,
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid();
        if (m_exl == 0)
            advance("pre_rst_irq", 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 0);
        advance("in_handler", 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        m_pc = 'h1000; m_epc = 0; m_exl = 0;
        check_arch("mid_rst");
        if (ir_valid !== 1'b0 || ir !== 32'h0) begin
            failures++; $display("FAIL mid_rst ir got=%h/%b exp=0/0", ir, ir_valid);
        end
        checks++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        if (ir !== 32'h3C010001 || ir_valid !== 1'b1 || pc !== 13'h1000) begin
            failures++;
            $display("FAIL refetch ir/pc got=%h/%h exp=3c010001/1000", ir, pc);
        end
        checks++;
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) mem[a] = $urandom;
        mem[13'h1000 / 4] = 32'h3C010001;
        npc_we = 1'b0; npc_sel = 2'd0; br_taken = 1'b0; imm16 = '0;
        j_index = '0; jr_target = '0; eret = 1'b0; irq = 1'b0; rst_n = 1'b0;
        test_reset();
        test_seq_stall();
        test_flow();
        test_irq();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ifu
`default_nettype wire
